complex_addsub_pipe: RTL and testbench
======================================

Name: complex_addsub_pipe

Overview:
- Parametrised, pipelined complex adder/subtractor for FFT butterfly datapaths; successor to the fixed 32-bit (16+16) complex subtractor.
- Per-transaction add/subtract select, optional divide-by-2 scaling, signed overflow detection with saturation, and per-component carry-outs.
- Sits between the twiddle multiplier and the butterfly output register bank.
- Valid/ready handshake on both sides, so it can stall under memory back-pressure.

Parameters:
- W, 16, bits per real/imag component (two's complement), W >= 4.
- STAGES, 2, pipeline register stages (accept-to-output latency in cycles), STAGES >= 1.
- SAT, 1, 1 = clamp on signed overflow; 0 = wrap.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input transaction valid.
- IN_READY  out  1  block can accept this cycle.
- MODE_SUB  in  1  1 = A-B, 0 = A+B; sampled with the transaction.
- DIV2  in  1  1 = arithmetic shift right by 1 of full-precision result; sampled with the transaction.
- A  in  2W  operand A, real in [2W-1:W], imag in [W-1:0].
- B  in  2W  operand B, same packing as A.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts.
- R  out  2W  result, same packing as A.
- C_OUT  out  2  unsigned carry-out {real, imag}; for subtract, carry = no-borrow (A + ~B + 1).
- OVF  out  2  signed overflow {real, imag} of this result; 0 when DIV2 = 1.
- OVF_STICKY  out  1  set by any accepted output with OVF != 0.
- CLR_OVF  in  1  synchronous clear of OVF_STICKY.

Behaviour:
- Reset (async, immediate): all stage valid bits 0, OUT_VALID = 0, R = 0, C_OUT = 0, OVF = 0, OVF_STICKY = 0.
- Pipeline: STAGES register slots, each with a valid bit.
  - Stage k loads when (slot k empty) or (slot k+1 loads / output handshakes).
  - IN_READY = stage-0 load condition (combinational ready chain; no skid buffer).
  - Transfer occurs when IN_VALID & IN_READY; output transfer when OUT_VALID & OUT_READY.
- Latency: exactly STAGES cycles from accept to OUT_VALID when unstalled. Throughput is 1 per cycle with OUT_READY held high.
- Arithmetic, per component, computed in stage 0:
  - s = sext(A) ± sext(B) at W+1 bits.
  - DIV2 = 0: result = s[W-1:0]; OVF = s[W] != s[W-1]. If SAT = 1 and OVF, result = 0x7F..F when s positive (s[W] = 0), 0x80..0 when negative.
  - DIV2 = 1: result = s[W:1] (floor); OVF = 0.
  - C_OUT is the carry out of the unsigned W-bit operation, independent of DIV2/SAT.
- Later stages carry R, C_OUT, OVF unchanged. Order is strictly preserved; no drop, no duplication.
- Stalls: with OUT_VALID = 1 and OUT_READY = 0, R/C_OUT/OVF hold stable. Once all slots are full, IN_READY = 0.
- OVF_STICKY:
  - Set on output handshake with |OVF.
  - Cleared by CLR_OVF.
  - Set and clear in the same cycle: set wins.
- Reset mid-operation: in-flight data is discarded; nothing emerges after release.
- Bubbles: stages with valid = 0 do not affect outputs; R holds its last value while OUT_VALID = 0.

Decomposition:
- Shared package/include: MODE_ADD/MODE_SUB encodings, component pack/unpack macros (RE/IM slice by W), saturation constants as functions of W.
- One natural sub-module: complex_addsub_slice (combinational W-bit signed add/sub with DIV2, SAT, carry, overflow), instantiated twice (real, imag).
- Pipeline/handshake logic and sticky flag live in the top module.

Test Plan (W = 16, STAGES = 2 unless noted):
- Subtract A = {0x0005, 0x0003}, B = {0x0002, 0x0007}, MODE_SUB = 1, DIV2 = 0 -> after 2 cycles: R = {0x0003, 0xFFFC}, C_OUT = 2'b10, OVF = 2'b00.
- Add A.re = 0x7FFF, B.re = 0x0001, SAT = 1 -> R.re = 0x7FFF, OVF[1] = 1, OVF_STICKY = 1 after handshake. Same with SAT = 0 -> R.re = 0x8000, OVF[1] = 1.
- DIV2 = 1:
  - 0x7FFF + 0x7FFF -> R = 0x7FFF, OVF = 0.
  - 0x8000 - 0x7FFF -> R = 0x8000, OVF = 0.
  - 0x0001 - 0x0002 -> R = 0xFFFF.
- Back-pressure: 6 back-to-back transactions, OUT_READY low for cycles 3-6 -> IN_READY falls once 2 slots are full, outputs stable while stalled, all 6 results emerge in order, no duplicates.
- Sticky control: overflowing result handshakes in the same cycle CLR_OVF = 1 -> OVF_STICKY = 1. Next cycle CLR_OVF = 1 with no overflow -> OVF_STICKY = 0.
- Async RST pulse mid-cycle with 2 transactions in flight -> OUT_VALID = 0 and R = 0 immediately, no output after release. Repeat the first scenario with STAGES = 1 -> latency 1 cycle.

Source files
------------

// File: rtl/complex_addsub_pipe_pkg.sv
// complex_addsub_pipe_pkg
//   Shared definitions for the pipelined complex adder/subtractor:
//   - mode_e: add/subtract operation encoding
//   - CPLX_RE / CPLX_IM / CPLX_PACK: component slicing of a packed {re, im} word
//   - CPLX_SAT_POS / CPLX_SAT_NEG: W-bit two's complement saturation limits
`ifndef COMPLEX_ADDSUB_PIPE_PKG_SV
`define COMPLEX_ADDSUB_PIPE_PKG_SV

`define CPLX_RE(v, w) v[2*(w)-1:(w)]
`define CPLX_IM(v, w) v[(w)-1:0]
`define CPLX_PACK(re, im) {re, im}
`define CPLX_SAT_POS(w) {1'b0, {((w)-1){1'b1}}}
`define CPLX_SAT_NEG(w) {1'b1, {((w)-1){1'b0}}}

package complex_addsub_pipe_pkg;

    typedef enum logic {
        MODE_ADD_ENC = 1'b0,
        MODE_SUB_ENC = 1'b1
    } mode_e;

    // Narrowest component width the datapath is designed for.
    localparam int unsigned MIN_W = 4;

endpackage

`endif

// File: rtl/complex_addsub_slice.sv
// complex_addsub_slice
//   Combinational W-bit signed add/subtract of one complex component.
//   Ports:
//     a, b   in   W  operands (two's complement)
//     op     in   1  MODE_ADD_ENC: a+b, MODE_SUB_ENC: a-b
//     div2   in   1  arithmetic shift right by 1 of the full-precision sum
//     r      out  W  result (saturated when SAT=1 and signed overflow)
//     carry  out  1  unsigned carry-out (no-borrow when subtracting)
//     ovf    out  1  signed overflow of r (always 0 when div2=1)
module complex_addsub_slice
    import complex_addsub_pipe_pkg::*;
#(
    parameter int unsigned W   = 16,
    parameter bit          SAT = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  mode_e        op,
    input  logic         div2,
    output logic [W-1:0] r,
    output logic         carry,
    output logic         ovf
);

    logic         sub;
    logic [W-1:0] b_eff;
    logic [W:0]   s_full;
    logic         ovf_raw;

    assign sub   = (op == MODE_SUB_ENC);
    assign b_eff = sub ? ~b : b;

    // sext(~b) == ~sext(b), so this is sext(a) +/- sext(b) at W+1 bits.
    assign s_full = {a[W-1], a} + {b_eff[W-1], b_eff} + {{W{1'b0}}, sub};

    // Bit W of the sign-extended sum is a_msb ^ b_msb ^ (carry out of bit W-1),
    // so the unsigned carry can be recovered from the same adder.
    assign carry   = s_full[W] ^ a[W-1] ^ b_eff[W-1];
    assign ovf_raw = s_full[W] ^ s_full[W-1];

    always_comb begin
        r   = s_full[W-1:0];
        ovf = 1'b0;
        if (div2) begin
            r = s_full[W:1];
        end else begin
            ovf = ovf_raw;
            if (SAT && ovf_raw) begin
                r = s_full[W] ? `CPLX_SAT_NEG(W) : `CPLX_SAT_POS(W);
            end
        end
    end

endmodule

// File: rtl/complex_addsub_pipe.sv
// complex_addsub_pipe
//   Pipelined complex adder/subtractor with valid/ready handshake on both sides.
//   The arithmetic is evaluated on accept; STAGES register slots carry the result.
//   Ports:
//     CLK, RST           clock (rising edge), asynchronous active-high reset
//     IN_VALID/IN_READY  input handshake
//     MODE_SUB, DIV2     per-transaction operation select and halving
//     A, B               packed {re, im} operands, 2W bits
//     OUT_VALID/OUT_READY output handshake
//     R                  packed {re, im} result
//     C_OUT, OVF         {re, im} carry-out and signed overflow of R
//     OVF_STICKY         set by any output handshake with OVF != 0
//     CLR_OVF            synchronous clear of OVF_STICKY (a same-cycle set wins)
module complex_addsub_pipe
    import complex_addsub_pipe_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned STAGES = 2,
    parameter bit          SAT    = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic           MODE_SUB,
    input  logic           DIV2,
    input  logic [2*W-1:0] A,
    input  logic [2*W-1:0] B,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] R,
    output logic [1:0]     C_OUT,
    output logic [1:0]     OVF,
    output logic           OVF_STICKY,
    input  logic           CLR_OVF
);

    logic [W-1:0] r_re, r_im;
    logic         c_re, c_im;
    logic         o_re, o_im;
    mode_e        op;

    assign op = MODE_SUB ? MODE_SUB_ENC : MODE_ADD_ENC;

    complex_addsub_slice #(
        .W   (W),
        .SAT (SAT)
    ) u_slice_re (
        .a     (`CPLX_RE(A, W)),
        .b     (`CPLX_RE(B, W)),
        .op    (op),
        .div2  (DIV2),
        .r     (r_re),
        .carry (c_re),
        .ovf   (o_re)
    );

    complex_addsub_slice #(
        .W   (W),
        .SAT (SAT)
    ) u_slice_im (
        .a     (`CPLX_IM(A, W)),
        .b     (`CPLX_IM(B, W)),
        .op    (op),
        .div2  (DIV2),
        .r     (r_im),
        .carry (c_im),
        .ovf   (o_im)
    );

    logic [STAGES-1:0] vld_q;
    logic [2*W-1:0]    r_q   [STAGES];
    logic [1:0]        c_q   [STAGES];
    logic [1:0]        ovf_q [STAGES];
    logic [STAGES-1:0] load;
    logic              out_fire;

    // Ready ripples back from the output: a slot may load when it is empty
    // or when its own contents move on this cycle.
    always_comb begin
        logic ripple;
        ripple            = ~vld_q[STAGES-1] | OUT_READY;
        load              = '0;
        load[STAGES-1]    = ripple;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            ripple  = ~vld_q[k] | ripple;
            load[k] = ripple;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                r_q[k]   <= '0;
                c_q[k]   <= '0;
                ovf_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0] <= IN_VALID;
                // Data only moves with a valid token so R holds across bubbles.
                if (IN_VALID) begin
                    r_q[0]   <= `CPLX_PACK(r_re, r_im);
                    c_q[0]   <= {c_re, c_im};
                    ovf_q[0] <= {o_re, o_im};
                end
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        r_q[k]   <= r_q[k-1];
                        c_q[k]   <= c_q[k-1];
                        ovf_q[k] <= ovf_q[k-1];
                    end
                end
            end
        end
    end

    assign IN_READY  = load[0];
    assign OUT_VALID = vld_q[STAGES-1];
    assign R         = r_q[STAGES-1];
    assign C_OUT     = c_q[STAGES-1];
    assign OVF       = ovf_q[STAGES-1];
    assign out_fire  = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF_STICKY <= 1'b0;
        end else if (out_fire && (|OVF)) begin
            OVF_STICKY <= 1'b1;
        end else if (CLR_OVF) begin
            OVF_STICKY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complex_addsub_pipe.sv
module tb_complex_addsub_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        div2;
        logic [31:0] r;
        logic [1:0]  c;
        logic [1:0]  ovf;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [1:0]  c;
        logic [1:0]  ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mode_sub, div2;
    logic [31:0] a, b, r;
    logic        out_valid, out_ready, ovf_sticky, clr_ovf;
    logic [1:0]  c_out, ovf;

    // Secondary instances (STAGES=1 and SAT=0) share one small input set.
    logic        x_valid, x_sub, x_div2, x_ready, x_clr;
    logic [31:0] x_a, x_b;
    logic        s1_in_ready, s1_out_valid, s1_sticky;
    logic [31:0] s1_r;
    logic [1:0]  s1_c, s1_ovf;
    logic        w_in_ready, w_out_valid, w_sticky;
    logic [31:0] w_r;
    logic [1:0]  w_c, w_ovf;

    int   nvec = 0;
    int   nfail = 0;
    exp_t sb[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    complex_addsub_pipe #(.W(16), .STAGES(2), .SAT(1'b1)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .MODE_SUB(mode_sub), .DIV2(div2), .A(a), .B(b),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .R(r), .C_OUT(c_out),
        .OVF(ovf), .OVF_STICKY(ovf_sticky), .CLR_OVF(clr_ovf)
    );

    complex_addsub_pipe #(.W(16), .STAGES(1), .SAT(1'b1)) dut_s1 (
        .CLK(clk), .RST(rst), .IN_VALID(x_valid), .IN_READY(s1_in_ready),
        .MODE_SUB(x_sub), .DIV2(x_div2), .A(x_a), .B(x_b),
        .OUT_VALID(s1_out_valid), .OUT_READY(x_ready), .R(s1_r), .C_OUT(s1_c),
        .OVF(s1_ovf), .OVF_STICKY(s1_sticky), .CLR_OVF(x_clr)
    );

    complex_addsub_pipe #(.W(16), .STAGES(2), .SAT(1'b0)) dut_w (
        .CLK(clk), .RST(rst), .IN_VALID(x_valid), .IN_READY(w_in_ready),
        .MODE_SUB(x_sub), .DIV2(x_div2), .A(x_a), .B(x_b),
        .OUT_VALID(w_out_valid), .OUT_READY(x_ready), .R(w_r), .C_OUT(w_c),
        .OVF(w_ovf), .OVF_STICKY(w_sticky), .CLR_OVF(x_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference for one component, computed with plain integers.
    function automatic void comp(input logic [15:0] x, input logic [15:0] y,
                                 input logic sub, input logic dv, input logic sat,
                                 output logic [15:0] rr, output logic cc, output logic oo);
        int sx, sy, s, ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {16'd0, x};
        uy = {16'd0, y};
        s  = sub ? sx - sy : sx + sy;
        cc = sub ? (ux >= uy) : (ux + uy > 65535);
        oo = 1'b0;
        if (dv) begin
            rr = 16'(s >>> 1);
        end else if (s > 32767 || s < -32768) begin
            oo = 1'b1;
            rr = sat ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'(s);
        end else begin
            rr = 16'(s);
        end
    endfunction

    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_,
                                   input logic sub, input logic dv);
        exp_t        e;
        logic [15:0] rre, rim;
        logic        cre, cim, ore, oim;
        comp(ta[31:16], tb_[31:16], sub, dv, 1'b1, rre, cre, ore);
        comp(ta[15:0], tb_[15:0], sub, dv, 1'b1, rim, cim, oim);
        e.r   = {rre, rim};
        e.c   = {cre, cim};
        e.ovf = {ore, oim};
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic td, input exp_t e);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        in_valid = 1'b1;
        a = ta; b = tb_; mode_sub = ts; div2 = td;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL send_timeout: IN_READY stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_output: got R=%h, required no output", r);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_R", 64'(r), 64'(e.r));
                check("sb_C_OUT", 64'(c_out), 64'(e.c));
                check("sb_OVF", 64'(ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap_r;
        int          n;
        bit          rand_bp;

        tbl[0] = '{a: 32'h00050003, b: 32'h00020007, sub: 1, div2: 0, r: 32'h0003FFFC, c: 2'b10, ovf: 2'b00};
        tbl[1] = '{a: 32'h7FFF0000, b: 32'h00010000, sub: 0, div2: 0, r: 32'h7FFF0000, c: 2'b00, ovf: 2'b10};
        tbl[2] = '{a: 32'h7FFF7FFF, b: 32'h7FFF7FFF, sub: 0, div2: 1, r: 32'h7FFF7FFF, c: 2'b00, ovf: 2'b00};
        tbl[3] = '{a: 32'h80000001, b: 32'h7FFF0002, sub: 1, div2: 1, r: 32'h8000FFFF, c: 2'b10, ovf: 2'b00};
        tbl[4] = '{a: 32'h80001234, b: 32'hFFFF1111, sub: 0, div2: 0, r: 32'h80002345, c: 2'b10, ovf: 2'b10};
        tbl[5] = '{a: 32'h00007FFF, b: 32'h0000FFFF, sub: 1, div2: 0, r: 32'h00007FFF, c: 2'b10, ovf: 2'b01};
        tbl[6] = '{a: 32'h80000003, b: 32'h80000000, sub: 0, div2: 1, r: 32'h80000001, c: 2'b10, ovf: 2'b00};
        tbl[7] = '{a: 32'h00000000, b: 32'h00000000, sub: 1, div2: 0, r: 32'h00000000, c: 2'b11, ovf: 2'b00};

        rst = 1'b1;
        in_valid = 0; mode_sub = 0; div2 = 0; a = '0; b = '0; out_ready = 1; clr_ovf = 0;
        x_valid = 0; x_sub = 0; x_div2 = 0; x_a = '0; x_b = '0; x_ready = 1; x_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_OUT_VALID", 64'(out_valid), 64'd0);
        check("reset_R", 64'(r), 64'd0);
        check("reset_C_OUT", 64'(c_out), 64'd0);
        check("reset_OVF", 64'(ovf), 64'd0);
        check("reset_OVF_STICKY", 64'(ovf_sticky), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_IN_READY", 64'(in_ready), 64'd1);

        // STAGES=1 latency and SAT=0 wrap on the secondary instances.
        x_valid = 1; x_sub = 1; x_a = 32'h00050003; x_b = 32'h00020007;
        @(posedge clk);
        #1;
        x_valid = 0;
        check("s1_latency1_OUT_VALID", 64'(s1_out_valid), 64'd1);
        check("s1_R", 64'(s1_r), 64'h0003FFFC);
        check("s1_C_OUT", 64'(s1_c), 64'b10);
        check("w_not_yet_valid", 64'(w_out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("w_latency2_R", 64'(w_r), 64'h0003FFFC);
        check("s1_drained", 64'(s1_out_valid), 64'd0);
        x_valid = 1; x_sub = 0; x_a = 32'h7FFF0000; x_b = 32'h00010000;
        @(posedge clk);
        #1;
        x_valid = 0;
        check("s1_sat_R", 64'(s1_r), 64'h7FFF0000);
        check("s1_sat_OVF", 64'(s1_ovf), 64'b10);
        @(posedge clk);
        #1;
        check("w_wrap_R", 64'(w_r), 64'h80000000);
        check("w_wrap_OVF", 64'(w_ovf), 64'b10);
        check("w_wrap_C_OUT", 64'(w_c), 64'b00);

        // Table vectors, back to back.
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.r = tbl[i].r; e.c = tbl[i].c; e.ovf = tbl[i].ovf;
            send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].div2, e);
        end
        drain();
        check("sticky_after_table", 64'(ovf_sticky), 64'd1);
        clr_ovf = 1;
        @(posedge clk);
        #1;
        clr_ovf = 0;
        check("sticky_cleared", 64'(ovf_sticky), 64'd0);

        // Latency with the pipeline empty.
        in_valid = 1; a = tbl[0].a; b = tbl[0].b; mode_sub = 1; div2 = 0;
        sb.push_back(model(tbl[0].a, tbl[0].b, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_stages2", 64'(n), 64'd2);
        drain();

        // Overflow handshake coincides with CLR_OVF: the set wins.
        clr_ovf = 1;
        send(tbl[1].a, tbl[1].b, 1'b0, 1'b0, model(tbl[1].a, tbl[1].b, 1'b0, 1'b0));
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sticky_before_handshake", 64'(ovf_sticky), 64'd0);
        @(posedge clk);
        #1;
        check("sticky_set_wins", 64'(ovf_sticky), 64'd1);
        @(posedge clk);
        #1;
        check("sticky_clear_next", 64'(ovf_sticky), 64'd0);
        clr_ovf = 0;

        // Back-pressure: two fill the pipe, four more once released.
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            send(ra, rb, i[0], 1'b0, model(ra, rb, i[0], 1'b0));
        end
        check("bp_IN_READY_low", 64'(in_ready), 64'd0);
        check("bp_OUT_VALID", 64'(out_valid), 64'd1);
        cap_r = r;
        repeat (3) @(posedge clk);
        #1;
        check("bp_R_stable", 64'(r), 64'(cap_r));
        check("bp_IN_READY_still_low", 64'(in_ready), 64'd0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            send(ra, rb, i[1], i[0], model(ra, rb, i[1], i[0]));
        end
        drain();

        // Random traffic with random downstream stalls.
        rand_bp = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] ra, rb;
                    logic        rs, rd;
                    ra = $urandom; rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    rd = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, rd, model(ra, rb, rs, rd));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_bp = 1'b0;
            end
            begin
                while (rand_bp) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        drain();

        // Asynchronous reset with two transactions in flight.
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom | 32'h00010001; rb = $urandom;
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_async_OUT_VALID", 64'(out_valid), 64'd0);
        check("rst_async_R", 64'(r), 64'd0);
        #3;
        rst = 1'b0;
        out_ready = 1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("rst_no_output_after", 64'(n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
